estagio_busca: RTL
==================

# estagio_busca

Instruction-fetch stage of the 5-stage pipeline: owns the program counter, issues requests to instruction memory, and drives the IF/ID pipeline register. It sits directly upstream of the hazard detection unit. It consumes that unit's `PCWrite`/`IFIDWrite` stall controls and supplies the `IFIDrs`/`IFIDrt` fields the unit compares against the ID/EX destination. It also handles taken-branch/jump redirects from EX, including a redirect that arrives while a memory fetch is still outstanding.

## Interface
- `WIDTH`, 32: PC and instruction width.
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `STALL_CNT_W`, 16: width of the stall counter.

- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `PCWrite`  in  1  1 = PC may advance; 0 = hold PC (load-use stall).
- `IFIDWrite`  in  1  1 = IF/ID may load; 0 = hold IF/ID contents.
- `redirect`  in  1  taken branch/jump resolved in EX; flush request.
- `redirect_pc`  in  WIDTH  target address, valid when `redirect`=1.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  WIDTH  fetch address (= PC register).
- `imem_rdata`  in  WIDTH  instruction; valid only in a cycle with `imem_req` & `imem_ready`.
- `imem_ready`  in  1  fetch completes this cycle.
- `IFID_instr`  out  WIDTH  registered instruction (0 = NOP when bubble).
- `IFID_pc4`  out  WIDTH  registered PC+4 of that instruction.
- `IFID_valid`  out  1  IF/ID holds a real instruction.
- `IFIDrs`  out  5  `IFID_instr[25:21]`.
- `IFIDrt`  out  5  `IFID_instr[20:16]`.
- `stall_count`  out  STALL_CNT_W  saturating count of hazard-stall cycles.

## Operation
- FSM states: `S_BOOT`, `S_FETCH`, `S_DRAIN`.
- Reset value of every output and register:
  - `pc` = `RESET_PC`
  - `IFID_instr` = 0, `IFID_pc4` = 0, `IFID_valid` = 0
  - `stall_count` = 0
  - `pend_pc` = 0
  - state = `S_BOOT`
  - `imem_req` = 0
- `S_BOOT`: `imem_req` = 0. Next state is `S_FETCH` unconditionally; `redirect` is ignored here.
- `S_FETCH`: `imem_req` = 1, `imem_addr` = `pc`. Priority order, evaluated per edge:
  1. `redirect` & `imem_ready`: `pc` <= `redirect_pc`. IF/ID <= bubble (`instr` = 0, `pc4` = 0, `valid` = 0). The ignored `PCWrite`/`IFIDWrite` have no effect, and the fetched word is discarded.
  2. `redirect` & !`imem_ready`: `pend_pc` <= `redirect_pc`; `pc` is unchanged; IF/ID <= bubble; go to `S_DRAIN`.
  3. `imem_ready`:
     - if `PCWrite`: `pc` <= `pc`+4.
     - if `IFIDWrite`: IF/ID <= {`imem_rdata`, `pc`+4, valid 1}.
     - `PCWrite`=0 refetches the same address next cycle. The two enables act independently.
  4. !`imem_ready`: if `IFIDWrite`, IF/ID <= bubble (memory-wait bubble); otherwise hold. `pc` holds.
- `S_DRAIN`: `imem_req` = 1; `imem_addr` = old `pc`, held stable until ready. IF/ID holds the bubble.
  - A new `redirect` overwrites `pend_pc`.
  - On `imem_ready`: data is discarded, `pc` <= `pend_pc` (or `redirect_pc` if `redirect` is also asserted that cycle), and the FSM returns to `S_FETCH`.
- `stall_count`: +1 on every edge in `S_FETCH` with `PCWrite`=0 and `redirect`=0. It saturates at all-ones; it does not wrap.
- PC arithmetic is modulo 2^WIDTH: `pc`+4 from 32'hFFFF_FFFC wraps to 0. Bits [1:0] of `redirect_pc` are forced to 0.

## Timing
- `imem_addr`, `imem_req`, `IFIDrs` and `IFIDrt` are combinational from registers only; there is no input-to-output combinational path.
- Zero-wait memory: an instruction at `pc` appears on `IFID_instr` one edge after the request, giving a throughput of 1 instruction/cycle.
- Redirect in `S_FETCH` with ready: the target is requested the cycle after the edge. Exactly one bubble reaches IF/ID.
- Redirect with an outstanding fetch: the target is requested the cycle after the pending fetch completes.
- `imem_addr` never changes while `imem_req` & !`imem_ready`.
- `reset` asserted mid-fetch or mid-drain returns to the reset values immediately. The pending redirect and any in-flight data are dropped.

## Structure
- Shared pipeline package holds:
  - the FSM state enum,
  - the `NOP` constant (0),
  - rs/rt field positions (25:21, 20:16), shared with the hazard and decode stages,
  - the PC increment constant (4).
- One sub-module: `registrador_ifid`, the IF/ID register with load-enable, bubble and async reset. The FSM, PC and counter stay in `estagio_busca`.

## Test plan
- Reset, then `imem_ready`=1, `PCWrite`=`IFIDWrite`=1, memory returns address-tagged words → `imem_addr` sequence 0, 4, 8, 12 on consecutive cycles. `IFID_instr` follows one cycle later with `IFID_pc4` = 4, 8, 12, 16.
- Hold `PCWrite`=`IFIDWrite`=0 for 3 cycles at `pc`=8 → `imem_addr` stays 8, IF/ID unchanged, `stall_count`=3. On release, the word at 8 loads with `pc4`=12.
- `redirect`=1, `redirect_pc`=32'h40 with ready, at `pc`=12 → one bubble (`valid`=0, `instr`=0), then `imem_addr`=32'h40.
- `imem_ready`=0 for 2 cycles with `redirect` to 32'h80 in the first → `imem_addr` stays at the old `pc` until ready. The old data is discarded, then `imem_addr`=32'h80.
- Redirect to 32'hFFFF_FFFC, run 2 fetches → `imem_addr` goes FFFF_FFFC then 0. Separately, force 2^16 stall cycles → `stall_count` holds 16'hFFFF.
- Assert `reset` during `S_DRAIN` → all outputs return to their reset values within the same cycle, and fetch restarts at `RESET_PC` after `S_BOOT`.

Source files
------------

// File: rtl/estagio_busca_pkg.sv
// Shared pipeline definitions: fetch FSM states, NOP encoding, register-field
// positions used by fetch, hazard detection and decode, and the PC step.
package estagio_busca_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_DRAIN
    } estado_busca_e;

    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam int unsigned RS_MSB = 25;
    localparam int unsigned RS_LSB = 21;
    localparam int unsigned RT_MSB = 20;
    localparam int unsigned RT_LSB = 16;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/estagio_busca_registrador_ifid.sv
// IF/ID pipeline register: bubble has priority over load; otherwise contents hold.
module registrador_ifid
    import estagio_busca_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic             bubble_i,
    input  logic [WIDTH-1:0] instr_i,
    input  logic [WIDTH-1:0] pc4_i,
    output logic [WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0] pc4_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] instr_q;
    logic [WIDTH-1:0] pc4_q;
    logic             valid_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_q <= WIDTH'(NOP);
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else if (bubble_i) begin
            instr_q <= WIDTH'(NOP);
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/estagio_busca.sv
// Instruction-fetch stage: PC, fetch FSM with redirect-while-outstanding handling,
// hazard stall counter, and the IF/ID register.
module estagio_busca
    import estagio_busca_pkg::*;
#(
    parameter int unsigned           WIDTH       = 32,
    parameter logic [WIDTH-1:0]      RESET_PC    = '0,
    parameter int unsigned           STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   PCWrite,
    input  logic                   IFIDWrite,
    input  logic                   redirect,
    input  logic [WIDTH-1:0]       redirect_pc,
    output logic                   imem_req,
    output logic [WIDTH-1:0]       imem_addr,
    input  logic [WIDTH-1:0]       imem_rdata,
    input  logic                   imem_ready,
    output logic [WIDTH-1:0]       IFID_instr,
    output logic [WIDTH-1:0]       IFID_pc4,
    output logic                   IFID_valid,
    output logic [4:0]             IFIDrs,
    output logic [4:0]             IFIDrt,
    output logic [STALL_CNT_W-1:0] stall_count
);

    estado_busca_e          state_q, state_d;
    logic [WIDTH-1:0]       pc_q, pc_d;
    logic [WIDTH-1:0]       pend_pc_q, pend_pc_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   ifid_load, ifid_bubble;
    logic [WIDTH-1:0]       pc_inc;
    logic [WIDTH-1:0]       target;

    assign pc_inc = pc_q + WIDTH'(PC_INC);
    // Targets are word aligned; low two bits of the request are dropped.
    assign target = redirect_pc & ~WIDTH'(3);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_pc_d   = pend_pc_q;
        stall_d     = stall_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        unique case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                if (!PCWrite && !redirect && stall_q != '1) begin
                    stall_d = stall_q + STALL_CNT_W'(1);
                end
                if (redirect && imem_ready) begin
                    pc_d        = target;
                    ifid_bubble = 1'b1;
                end else if (redirect) begin
                    pend_pc_d   = target;
                    ifid_bubble = 1'b1;
                    state_d     = S_DRAIN;
                end else if (imem_ready) begin
                    if (PCWrite) pc_d = pc_inc;
                    ifid_load = IFIDWrite;
                end else begin
                    ifid_bubble = IFIDWrite;
                end
            end
            S_DRAIN: begin
                if (redirect) pend_pc_d = target;
                if (imem_ready) begin
                    pc_d    = redirect ? target : pend_pc_q;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_BOOT;
            pc_q      <= RESET_PC;
            pend_pc_q <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            stall_q   <= stall_d;
        end
    end

    registrador_ifid #(
        .WIDTH (WIDTH)
    ) u_ifid (
        .clock    (clock),
        .reset    (reset),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .instr_i  (imem_rdata),
        .pc4_i    (pc_inc),
        .instr_o  (IFID_instr),
        .pc4_o    (IFID_pc4),
        .valid_o  (IFID_valid)
    );

    assign imem_req    = (state_q != S_BOOT);
    assign imem_addr   = pc_q;
    assign IFIDrs      = IFID_instr[RS_MSB:RS_LSB];
    assign IFIDrt      = IFID_instr[RT_MSB:RT_LSB];
    assign stall_count = stall_q;

endmodule
